// File: rtl/pe_ctrl_pkg.sv
// Shared types and packet field helpers for the PE packet controller.
// Packet layout, MSB first: {type[1:0], addr[ADDR_W], ifmap field, filter field}.
package pe_ctrl_pkg;

  typedef enum logic [1:0] {
    PKT_IFMAP = 2'b00,
    PKT_FULL  = 2'b01,
    PKT_PSUM  = 2'b10,
    PKT_RSVD  = 2'b11
  } pkt_type_e;

  typedef enum logic [2:0] {
    StIdle,
    StLoadF,
    StLoadI,
    StStart,
    StWaitPsum,
    StSend,
    StWaitDone
  } state_e;

  function automatic int unsigned field_w(input int unsigned depth, input int unsigned width);
    return depth * width;
  endfunction

  // The ifmap field sits directly above the filter field.
  function automatic int unsigned ifmap_lsb(input int unsigned ff_w);
    return ff_w;
  endfunction

  function automatic int unsigned addr_lsb(input int unsigned fi_w, input int unsigned ff_w);
    return fi_w + ff_w;
  endfunction

  function automatic int unsigned type_lsb(input int unsigned addr_w, input int unsigned fi_w,
                                           input int unsigned ff_w);
    return addr_w + fi_w + ff_w;
  endfunction

  function automatic int unsigned pkt_width(input int unsigned addr_w, input int unsigned fi_w,
                                            input int unsigned ff_w);
    return 2 + addr_w + fi_w + ff_w;
  endfunction

endpackage

// File: rtl/pe_pkt_build.sv
// Combinational formatter for outbound psum packets.
// Ports:
//   psum - partial sum, zero-extended into the filter field
//   col  - output column tag, placed with OUT_ROW (zero-extended) in the ifmap field
//   pkt  - complete packet: {PKT_PSUM, TARGET_ADDR, {OUT_ROW, col}, psum}
module pe_pkt_build
  import pe_ctrl_pkg::*;
#(
  parameter int unsigned       PSUM_W      = 8,
  parameter int unsigned       ADDR_W      = 8,
  parameter int unsigned       ROW_W       = 2,
  parameter int unsigned       COL_W       = 2,
  parameter int unsigned       FI_W        = 5,
  parameter int unsigned       FF_W        = 24,
  parameter logic [ADDR_W-1:0] TARGET_ADDR = 8'h04,
  parameter logic [ROW_W-1:0]  OUT_ROW     = 2'b01,
  localparam int unsigned      PKT_W       = pkt_width(ADDR_W, FI_W, FF_W)
) (
  input  logic [PSUM_W-1:0] psum,
  input  logic [COL_W-1:0]  col,
  output logic [PKT_W-1:0]  pkt
);

  localparam int unsigned TypeLsb  = type_lsb(ADDR_W, FI_W, FF_W);
  localparam int unsigned AddrLsb  = addr_lsb(FI_W, FF_W);
  localparam int unsigned IfmapLsb = ifmap_lsb(FF_W);

  always_comb begin
    pkt = '0;
    pkt[TypeLsb +: 2]              = PKT_PSUM;
    pkt[AddrLsb +: ADDR_W]         = TARGET_ADDR;
    pkt[IfmapLsb +: ROW_W + COL_W] = {OUT_ROW, col};
    pkt[0 +: PSUM_W]               = psum;
  end

endmodule

// File: rtl/pe_ctrl_sync.sv
// PE packet controller: unpacks an inbound NoC packet into the PE filter/ifmap
// memories, starts the PE, then wraps each psum into an outbound packet.
// Ports:
//   pkt_in_*   - inbound packet handshake and data
//   pkt_out_*  - outbound psum packet handshake and data
//   f_*, i_*   - filter / ifmap memory write ports
//   pe_start   - one-cycle PE start pulse
//   psum_*     - psum handshake from the PE; pe_done - PE completion pulse
//   drop_cnt   - saturating count of discarded (type 10/11) packets
// Every output is a register loaded from the next-state values, so outputs line up
// with the state they belong to without any combinational input-to-output path.
module pe_ctrl_sync
  import pe_ctrl_pkg::*;
#(
  parameter int unsigned       WIDTH_I     = 1,
  parameter int unsigned       WIDTH_F     = 8,
  parameter int unsigned       DEPTH_I     = 5,
  parameter int unsigned       DEPTH_F     = 3,
  parameter int unsigned       PSUM_W      = 8,
  parameter int unsigned       ADDR_W      = 8,
  parameter int unsigned       ROW_W       = 2,
  parameter int unsigned       COL_W       = 2,
  parameter logic [ADDR_W-1:0] TARGET_ADDR = 8'h04,
  parameter logic [ROW_W-1:0]  OUT_ROW     = 2'b01,
  localparam int unsigned      PKT_W       = pkt_width(ADDR_W, field_w(DEPTH_I, WIDTH_I),
                                                       field_w(DEPTH_F, WIDTH_F)),
  localparam int unsigned      FA_W        = $clog2(DEPTH_F),
  localparam int unsigned      IA_W        = $clog2(DEPTH_I)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pkt_in_valid,
  output logic               pkt_in_ready,
  input  logic [PKT_W-1:0]   pkt_in_data,
  output logic               pkt_out_valid,
  input  logic               pkt_out_ready,
  output logic [PKT_W-1:0]   pkt_out_data,
  output logic               f_we,
  output logic [FA_W-1:0]    f_addr,
  output logic [WIDTH_F-1:0] f_wdata,
  output logic               i_we,
  output logic [IA_W-1:0]    i_addr,
  output logic [WIDTH_I-1:0] i_wdata,
  output logic               pe_start,
  input  logic               psum_valid,
  output logic               psum_ready,
  input  logic [PSUM_W-1:0]  psum_data,
  input  logic               pe_done,
  output logic [7:0]         drop_cnt
);

  localparam int unsigned FI_W    = field_w(DEPTH_I, WIDTH_I);
  localparam int unsigned FF_W    = field_w(DEPTH_F, WIDTH_F);
  localparam int unsigned ADDR_LO = addr_lsb(FI_W, FF_W);
  localparam int unsigned TYPE_LO = type_lsb(ADDR_W, FI_W, FF_W);
  localparam int unsigned N_OUT   = DEPTH_I - DEPTH_F + 1;
  localparam int unsigned IDX_W   = $clog2(N_OUT + 1);
  localparam int unsigned CNT_W   = (IA_W > FA_W) ? IA_W : FA_W;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [PSUM_W-1:0]      psum_q, psum_d;
  logic                   done_q, done_d;
  logic [7:0]             drop_d;
  logic [FI_W+FF_W-1:0]   fields_q, fields_d;
  logic [WIDTH_F-1:0]     f_elem;
  logic [WIDTH_I-1:0]     i_elem;
  logic [COL_W-1:0]       col;
  logic [PKT_W-1:0]       built_pkt;
  pkt_type_e              in_type;
  logic                   unused_addr;

  assign in_type     = pkt_type_e'(pkt_in_data[TYPE_LO +: 2]);
  // The inbound destination address is already resolved by the NoC.
  assign unused_addr = ^pkt_in_data[ADDR_LO +: ADDR_W];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    psum_d   = psum_q;
    done_d   = done_q;
    drop_d   = drop_cnt;
    fields_d = fields_q;
    unique case (state_q)
      StIdle: begin
        if (pkt_in_valid && pkt_in_ready) begin
          fields_d = pkt_in_data[FI_W+FF_W-1:0];
          cnt_d    = '0;
          unique case (in_type)
            PKT_FULL:  state_d = StLoadF;
            PKT_IFMAP: state_d = StLoadI;
            default: begin
              if (drop_cnt != 8'hFF) drop_d = drop_cnt + 8'd1;
            end
          endcase
        end
      end
      StLoadF: begin
        if (cnt_q == CNT_W'(DEPTH_F - 1)) begin
          state_d = StLoadI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StLoadI: begin
        if (cnt_q == CNT_W'(DEPTH_I - 1)) state_d = StStart;
        else                              cnt_d   = cnt_q + CNT_W'(1);
      end
      StStart: begin
        idx_d   = '0;
        state_d = StWaitPsum;
      end
      StWaitPsum: begin
        if (pe_done) done_d = 1'b1;
        if (psum_valid && psum_ready) begin
          psum_d  = psum_data;
          state_d = StSend;
        end
      end
      StSend: begin
        if (pe_done) done_d = 1'b1;
        if (pkt_out_valid && pkt_out_ready) begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = (idx_d == IDX_W'(N_OUT)) ? StWaitDone : StWaitPsum;
        end
      end
      StWaitDone: begin
        if (pe_done || done_q) begin
          done_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Element 0 of each field occupies its MSBs.
  always_comb begin
    f_elem = '0;
    for (int k = 0; k < int'(DEPTH_F); k++) begin
      if (cnt_d == CNT_W'(k)) f_elem = fields_d[(int'(DEPTH_F) - 1 - k) * WIDTH_F +: WIDTH_F];
    end
  end

  always_comb begin
    i_elem = '0;
    for (int k = 0; k < int'(DEPTH_I); k++) begin
      if (cnt_d == CNT_W'(k)) begin
        i_elem = fields_d[FF_W + (int'(DEPTH_I) - 1 - k) * WIDTH_I +: WIDTH_I];
      end
    end
  end

  // Column tag wraps naturally by truncation to COL_W.
  assign col = COL_W'(idx_q + IDX_W'(1));

  pe_pkt_build #(
    .PSUM_W      (PSUM_W),
    .ADDR_W      (ADDR_W),
    .ROW_W       (ROW_W),
    .COL_W       (COL_W),
    .FI_W        (FI_W),
    .FF_W        (FF_W),
    .TARGET_ADDR (TARGET_ADDR),
    .OUT_ROW     (OUT_ROW)
  ) u_build (
    .psum (psum_d),
    .col  (col),
    .pkt  (built_pkt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      idx_q         <= '0;
      psum_q        <= '0;
      done_q        <= 1'b0;
      fields_q      <= '0;
      drop_cnt      <= '0;
      pkt_in_ready  <= 1'b0;
      pkt_out_valid <= 1'b0;
      pkt_out_data  <= '0;
      f_we          <= 1'b0;
      f_addr        <= '0;
      f_wdata       <= '0;
      i_we          <= 1'b0;
      i_addr        <= '0;
      i_wdata       <= '0;
      pe_start      <= 1'b0;
      psum_ready    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      psum_q        <= psum_d;
      done_q        <= done_d;
      fields_q      <= fields_d;
      drop_cnt      <= drop_d;
      pkt_in_ready  <= (state_d == StIdle);
      pkt_out_valid <= (state_d == StSend);
      f_we          <= (state_d == StLoadF);
      f_addr        <= (state_d == StLoadF) ? cnt_d[FA_W-1:0] : '0;
      f_wdata       <= (state_d == StLoadF) ? f_elem : '0;
      i_we          <= (state_d == StLoadI);
      i_addr        <= (state_d == StLoadI) ? cnt_d[IA_W-1:0] : '0;
      i_wdata       <= (state_d == StLoadI) ? i_elem : '0;
      pe_start      <= (state_d == StStart);
      psum_ready    <= (state_d == StWaitPsum);
      // Loaded on entry to SEND and left alone while the packet waits for ready.
      if (state_d == StSend) pkt_out_data <= built_pkt;
    end
  end

endmodule
